// File: rtl/rle_block_sequencer.sv
// JPEG run-length sequencer: turns a 64-coefficient zig-zag block (8 per beat)
// into (run,value) symbols with ZRL splitting, cross-beat zero stitching and EOB.

module module_8bit_capsule (
   input  logic [63:0]       data_i,
   output logic              flag_o,
   output logic [3:0]        left_o,
   output logic [3:0]        right_o,
   output logic [3:0]        size_o,
   output logic [7:0][13:0]  arr_o
);

   logic [7:0][7:0] coef;
   logic [3:0]      cnt;
   logic [3:0]      nz;
   logic [3:0]      zr;
   logic [3:0]      lead;
   logic [2:0]      e;
   logic            seen;

   assign coef = data_i;

   // coef[7] is first in scan order; entries are filled latest-first
   always_comb begin
      arr_o = '0;
      cnt   = '0;
      nz    = '0;
      zr    = '0;
      lead  = '0;
      e     = '0;
      seen  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (coef[i[2:0]] != 8'd0) cnt = cnt + 4'd1;
      end
      for (int i = 7; i >= 0; i--) begin
         if (coef[i[2:0]] != 8'd0) begin
            e = 3'(cnt - nz - 4'd1);
            arr_o[e] = {(seen ? {2'b00, zr} : 6'd0), coef[i[2:0]]};
            seen = 1'b1;
            nz   = nz + 4'd1;
            zr   = '0;
         end else begin
            zr = zr + 4'd1;
            if (!seen) lead = lead + 4'd1;
         end
      end
   end

   assign flag_o  = (cnt != 4'd0);
   assign left_o  = lead;
   assign right_o = zr;
   assign size_o  = cnt;

endmodule

module rle_block_sequencer #(
   parameter int BEATS   = 8,
   parameter int MAX_RUN = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_run,
   output logic [7:0]  out_value,
   output logic        out_eob,
   output logic        blk_done,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_END} state_t;

   state_t            state_q, state_d;
   logic [2:0]        beat_cnt_q, beat_cnt_d;
   logic [6:0]        carry_q, carry_d;
   logic [2:0]        idx_q, idx_d;
   logic [6:0]        pend_q, pend_d;
   logic [7:0][13:0]  arr_q, arr_d;
   logic [3:0]        right_q, right_d;
   logic              last_q, last_d;
   logic              busy_q, busy_d;

   logic              cap_flag;
   logic [3:0]        cap_left;
   logic [3:0]        cap_right;
   logic [3:0]        cap_size;
   logic [7:0][13:0]  cap_arr;

   logic              accept;
   logic              zrl;
   logic              is_last;
   logic [2:0]        idx_m1;
   logic [6:0]        carry_sum;
   logic [6:0]        carry_sat;

   module_8bit_capsule u_cap (
      .data_i  (in_data),
      .flag_o  (cap_flag),
      .left_o  (cap_left),
      .right_o (cap_right),
      .size_o  (cap_size),
      .arr_o   (cap_arr)
   );

   assign accept    = in_valid & in_ready;
   assign zrl       = (pend_q > 7'(MAX_RUN));
   assign is_last   = (beat_cnt_q == 3'(BEATS - 1));
   assign idx_m1    = idx_q - 3'd1;
   assign carry_sum = carry_q + 7'd8;
   assign carry_sat = (carry_sum > 7'd64) ? 7'd64 : carry_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         beat_cnt_q <= '0;
         carry_q    <= '0;
         idx_q      <= '0;
         pend_q     <= '0;
         arr_q      <= '0;
         right_q    <= '0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         carry_q    <= carry_d;
         idx_q      <= idx_d;
         pend_q     <= pend_d;
         arr_q      <= arr_d;
         right_q    <= right_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      carry_d    = carry_q;
      idx_d      = idx_q;
      pend_d     = pend_q;
      arr_d      = arr_q;
      right_d    = right_q;
      last_d     = last_q;
      busy_d     = busy_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               beat_cnt_d = beat_cnt_q + 3'd1;
               busy_d     = 1'b1;
               last_d     = is_last;
               if (cap_flag) begin
                  arr_d   = cap_arr;
                  right_d = cap_right;
                  idx_d   = 3'(cap_size - 4'd1);
                  pend_d  = carry_q + {3'b000, cap_left};
                  state_d = S_EMIT;
               end else begin
                  carry_d = carry_sat;
                  if (is_last) state_d = S_END;
               end
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               if (zrl) begin
                  pend_d = pend_q - 7'(MAX_RUN + 1);
               end else if (idx_q == 3'd0) begin
                  carry_d = {3'b000, right_q};
                  if (!last_q) begin
                     state_d = S_IDLE;
                  end else if (right_q == 4'd0) begin
                     // block ended on a nonzero: no EOB
                     state_d    = S_IDLE;
                     carry_d    = '0;
                     beat_cnt_d = '0;
                     busy_d     = 1'b0;
                  end else begin
                     state_d = S_END;
                  end
               end else begin
                  idx_d  = idx_m1;
                  pend_d = {1'b0, arr_q[idx_m1][13:8]};
               end
            end
         end
         S_END: begin
            if ((carry_q == 7'd0) || out_ready) begin
               state_d    = S_IDLE;
               carry_d    = '0;
               beat_cnt_d = '0;
               busy_d     = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_run   = '0;
      out_value = '0;
      out_eob   = 1'b0;
      blk_done  = 1'b0;
      unique case (state_q)
         S_IDLE: in_ready = 1'b1;
         S_EMIT: begin
            out_valid = 1'b1;
            if (zrl) begin
               out_run = 4'(MAX_RUN);
            end else begin
               out_run   = pend_q[3:0];
               out_value = arr_q[idx_q][7:0];
               blk_done  = out_ready & (idx_q == 3'd0)
                         & last_q & (right_q == 4'd0);
            end
         end
         S_END: begin
            out_valid = (carry_q != 7'd0);
            out_eob   = (carry_q != 7'd0);
            blk_done  = (carry_q == 7'd0) | out_ready;
         end
         default: ;
      endcase
   end

   assign busy = busy_q;

endmodule

// File: tb/tb_rle_block_sequencer.sv
// Directed bench for rle_block_sequencer: hand-computed symbol streams
// with immediate-assertion checks at each comparison point.

module tb_rle_block_sequencer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_run;
   logic [7:0]  out_value;
   logic        out_eob;
   logic        blk_done;
   logic        busy;

   int total_cnt = 0;
   int pass_cnt  = 0;

   rle_block_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_run   (out_run),
      .out_value (out_value),
      .out_eob   (out_eob),
      .blk_done  (blk_done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send(input string tag, input logic [63:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      #1;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic zeros(input string tag, input int n);
      for (int i = 0; i < n; i++) send(tag, 64'd0);
   endtask

   task automatic expect_sym(input string tag, input logic [3:0] r,
                             input logic [7:0] v, input logic e,
                             input logic d, input int stall);
      for (int s = 0; s < stall; s++) begin
         out_ready = 1'b0;
         #1;
         chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_stall_run"}, 32'(out_run), 32'(r));
         chk({tag, "_stall_value"}, 32'(out_value), 32'(v));
         chk({tag, "_stall_done"}, 32'(blk_done), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_run"}, 32'(out_run), 32'(r));
      chk({tag, "_value"}, 32'(out_value), 32'(v));
      chk({tag, "_eob"}, 32'(out_eob), 32'(e));
      chk({tag, "_done"}, 32'(blk_done), 32'(d));
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic idle_chk(input string tag);
      #1;
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_done"}, 32'(blk_done), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_run", 32'(out_run), 32'd0);
      chk("rst_value", 32'(out_value), 32'd0);
      chk("rst_eob", 32'(out_eob), 32'd0);
      chk("rst_done", 32'(blk_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // all-zero block: only EOB
      zeros("t1", 8);
      chk("t1_busy", 32'(busy), 32'd1);
      expect_sym("t1_eob", 4'd0, 8'h00, 1'b1, 1'b1, 0);
      idle_chk("t1_post");

      // single DC coefficient
      send("t2_b0", 64'h0500_0000_0000_0000);
      chk("t2_busy", 32'(busy), 32'd1);
      expect_sym("t2_s0", 4'd0, 8'h05, 1'b0, 1'b0, 0);
      zeros("t2", 7);
      expect_sym("t2_eob", 4'd0, 8'h00, 1'b1, 1'b1, 0);
      idle_chk("t2_post");

      // coef 40 only: 40 zeros -> ZRL, ZRL, (8,0x12)
      zeros("t3", 5);
      send("t3_b5", 64'h1200_0000_0000_0000);
      expect_sym("t3_zrl0", 4'd15, 8'h00, 1'b0, 1'b0, 0);
      expect_sym("t3_zrl1", 4'd15, 8'h00, 1'b0, 1'b0, 0);
      expect_sym("t3_s", 4'd8, 8'h12, 1'b0, 1'b0, 0);
      zeros("t3", 2);
      expect_sym("t3_eob", 4'd0, 8'h00, 1'b1, 1'b1, 0);
      idle_chk("t3_post");

      // coef 63 only: 63 zeros -> 3 ZRL, (15,0x7F), no EOB
      zeros("t4", 7);
      send("t4_b7", 64'h0000_0000_0000_007F);
      expect_sym("t4_zrl0", 4'd15, 8'h00, 1'b0, 1'b0, 0);
      expect_sym("t4_zrl1", 4'd15, 8'h00, 1'b0, 1'b0, 0);
      expect_sym("t4_zrl2", 4'd15, 8'h00, 1'b0, 1'b0, 0);
      expect_sym("t4_s", 4'd15, 8'h7F, 1'b0, 1'b1, 0);
      idle_chk("t4_post");

      // mixed beat with back-pressure
      send("t5_b0", 64'h0100_0203_0000_0004);
      expect_sym("t5_s0", 4'd0, 8'h01, 1'b0, 1'b0, 2);
      expect_sym("t5_s1", 4'd1, 8'h02, 1'b0, 1'b0, 2);
      expect_sym("t5_s2", 4'd0, 8'h03, 1'b0, 1'b0, 2);
      expect_sym("t5_s3", 4'd3, 8'h04, 1'b0, 1'b0, 2);
      zeros("t5", 7);
      expect_sym("t5_eob", 4'd0, 8'h00, 1'b1, 1'b1, 2);
      idle_chk("t5_post");

      // reset while emitting drops the block
      send("t6_b0", 64'h0100_0203_0000_0004);
      expect_sym("t6_s0", 4'd0, 8'h01, 1'b0, 1'b0, 0);
      #1;
      chk("t6_pre_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_run", 32'(out_run), 32'd0);
      chk("t6_rst_value", 32'(out_value), 32'd0);
      chk("t6_rst_eob", 32'(out_eob), 32'd0);
      chk("t6_rst_done", 32'(blk_done), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      send("t6_f0", 64'h0500_0000_0000_0000);
      expect_sym("t6_fs0", 4'd0, 8'h05, 1'b0, 1'b0, 0);
      zeros("t6_f", 7);
      expect_sym("t6_feob", 4'd0, 8'h00, 1'b1, 1'b1, 0);
      idle_chk("t6_post");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
